seg7_bcd_decoder: RTL and testbench

SEG7_BCD_DECODER -- requirements
Module: seg7_bcd_decoder

---
 rtl/seg7_bcd_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_seg7_bcd_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_decoder.sv
// seg7_bcd_decoder
//   Debounces a raw 7-segment pattern, decodes it to a BCD digit and checks
//   that successive accepted digits count upward (mod 10).
//
//   Parameters
//     STABLE_CYCLES  consecutive identical samples needed to accept (1..15)
//     ACTIVE_LOW     1: seg_in segments are lit-when-0 and are inverted first
//
//   Ports
//     clk          rising-edge clock
//     rst_syn      asynchronous active-low reset
//     seg_in[7:0]  {dp,g,f,e,d,c,b,a}; dp is ignored
//     clr          synchronous clear of counters, flags and sequence history
//     digit        last accepted BCD digit (held across illegal patterns)
//     digit_valid  high while a legal pattern is locked
//     new_digit    one-cycle pulse on each legal acceptance
//     illegal      one-cycle pulse on acceptance of a non-digit pattern
//     step_err     one-cycle pulse on an out-of-sequence digit
//     err_cnt      saturating count of illegal + step_err events
//     dig_cnt      saturating count of legal acceptances
module seg7_bcd_decoder #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_syn,
  input  logic [7:0] seg_in,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       new_digit,
  output logic       illegal,
  output logic       step_err,
  output logic [7:0] err_cnt,
  output logic [7:0] dig_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED,
    BAD
  } state_e;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  state_e     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       new_digit_q, new_digit_d;
  logic       illegal_q, illegal_d;
  logic       step_err_q, step_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] dig_cnt_q, dig_cnt_d;
  logic       hist_valid_q, hist_valid_d;

  logic [6:0] seg_n;
  logic       dec_legal;
  logic [3:0] dec_val;
  logic [3:0] exp_next;
  logic       accept;

  // Decimal point carries no digit information.
  logic unused_dp;
  assign unused_dp = seg_in[7];

  always_comb begin
    seg_n = ACTIVE_LOW ? ~seg_in[6:0] : seg_in[6:0];
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_val   = '0;
    case (seg_n)
      7'h3F:   dec_val = 4'd0;
      7'h06:   dec_val = 4'd1;
      7'h5B:   dec_val = 4'd2;
      7'h4F:   dec_val = 4'd3;
      7'h66:   dec_val = 4'd4;
      7'h6D:   dec_val = 4'd5;
      7'h7D:   dec_val = 4'd6;
      7'h07:   dec_val = 4'd7;
      7'h7F:   dec_val = 4'd8;
      7'h6F:   dec_val = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  // digit_q doubles as the sequence history value: every legal acceptance
  // writes it, and history is only consulted while hist_valid_q is set.
  always_comb begin
    exp_next = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    new_digit_d   = 1'b0;
    illegal_d     = 1'b0;
    step_err_d    = 1'b0;
    err_cnt_d     = err_cnt_q;
    dig_cnt_d     = dig_cnt_q;
    hist_valid_d  = hist_valid_q;
    accept        = 1'b0;

    case (state_q)
      IDLE: begin
        cand_d  = seg_n;
        cnt_d   = 4'd1;
        state_d = SETTLE;
        accept  = (STABLE == 4'd1);
      end
      SETTLE: begin
        if (seg_n == cand_q) begin
          cnt_d  = cnt_q + 4'd1;
          accept = ((cnt_q + 4'd1) >= STABLE);
        end else begin
          cand_d = seg_n;
          cnt_d  = 4'd1;
          accept = (STABLE == 4'd1);
        end
      end
      LOCKED, BAD: begin
        if (seg_n != cand_q) begin
          digit_valid_d = 1'b0;
          cand_d        = seg_n;
          cnt_d         = 4'd1;
          state_d       = SETTLE;
          accept        = (STABLE == 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Every accepting path has seg_n equal to the candidate, so the
    // combinational decode of seg_n is the decode of the candidate.
    if (accept) begin
      if (dec_legal) begin
        digit_d       = dec_val;
        digit_valid_d = 1'b1;
        new_digit_d   = 1'b1;
        dig_cnt_d     = (dig_cnt_q == 8'hFF) ? dig_cnt_q : dig_cnt_q + 8'd1;
        hist_valid_d  = 1'b1;
        state_d       = LOCKED;
        if (hist_valid_q && (dec_val != exp_next)) begin
          step_err_d = 1'b1;
          err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end
      end else begin
        digit_valid_d = 1'b0;
        illegal_d     = 1'b1;
        err_cnt_d     = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        hist_valid_d  = 1'b0;
        state_d       = BAD;
      end
    end

    // clr overrides any acceptance computed above; digit is held.
    if (clr) begin
      state_d       = IDLE;
      cnt_d         = '0;
      digit_d       = digit_q;
      digit_valid_d = 1'b0;
      new_digit_d   = 1'b0;
      illegal_d     = 1'b0;
      step_err_d    = 1'b0;
      err_cnt_d     = '0;
      dig_cnt_d     = '0;
      hist_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      new_digit_q   <= 1'b0;
      illegal_q     <= 1'b0;
      step_err_q    <= 1'b0;
      err_cnt_q     <= '0;
      dig_cnt_q     <= '0;
      hist_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      new_digit_q   <= new_digit_d;
      illegal_q     <= illegal_d;
      step_err_q    <= step_err_d;
      err_cnt_q     <= err_cnt_d;
      dig_cnt_q     <= dig_cnt_d;
      hist_valid_q  <= hist_valid_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign new_digit   = new_digit_q;
  assign illegal     = illegal_q;
  assign step_err    = step_err_q;
  assign err_cnt     = err_cnt_q;
  assign dig_cnt     = dig_cnt_q;

endmodule

// File: tb/tb_seg7_bcd_decoder.sv
// tb_seg7_bcd_decoder
//   Directed-vector bench for seg7_bcd_decoder (STABLE_CYCLES=2, ACTIVE_LOW=0).
//   A run-length model predicts every output each cycle; literal expectations
//   pin the key scenarios.
module tb_seg7_bcd_decoder;

  localparam int S  = 2;
  localparam bit AL = 1'b0;

  logic       clk = 1'b0;
  logic       rst_syn;
  logic [7:0] seg_in;
  logic       clr;
  logic [3:0] digit;
  logic       digit_valid;
  logic       new_digit;
  logic       illegal;
  logic       step_err;
  logic [7:0] err_cnt;
  logic [7:0] dig_cnt;

  seg7_bcd_decoder #(
    .STABLE_CYCLES(S),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk        (clk),
    .rst_syn    (rst_syn),
    .seg_in     (seg_in),
    .clr        (clr),
    .digit      (digit),
    .digit_valid(digit_valid),
    .new_digit  (new_digit),
    .illegal    (illegal),
    .step_err   (step_err),
    .err_cnt    (err_cnt),
    .dig_cnt    (dig_cnt)
  );

  always #5 clk = ~clk;

  logic [6:0] segs [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int checks = 0;
  int errors = 0;

  // model state
  logic [6:0] m_last;
  int m_run, m_digit, m_err, m_dig;
  bit m_dv, m_nd, m_ill, m_se, m_hv;

  // per-scenario tallies of observed DUT pulses
  int nd_cnt, se_cnt, ill_cnt, saw8;

  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (segs[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = '0; m_run = 0; m_digit = 0; m_err = 0; m_dig = 0;
    m_dv = 0; m_nd = 0; m_ill = 0; m_se = 0; m_hv = 0;
  endtask

  // A pattern is accepted exactly when its run of identical samples
  // (counted since the last change, reset or clear) reaches S.
  task automatic model_edge();
    logic [6:0] p;
    int d;
    m_nd = 0; m_ill = 0; m_se = 0;
    if (clr) begin
      m_run = 0; m_err = 0; m_dig = 0; m_hv = 0; m_dv = 0;
    end else begin
      p = AL ? ~seg_in[6:0] : seg_in[6:0];
      if (m_run == 0 || p != m_last) begin
        m_run = 1; m_last = p;
      end else if (m_run < 1000) begin
        m_run++;
      end
      if (m_run == S) begin
        d = dec(p);
        if (d >= 0) begin
          m_se = m_hv && (d != (m_digit + 1) % 10);
          if (m_se) m_err = (m_err < 255) ? m_err + 1 : 255;
          m_digit = d; m_nd = 1; m_hv = 1;
          m_dig = (m_dig < 255) ? m_dig + 1 : 255;
        end else begin
          m_ill = 1; m_hv = 0;
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end
      end
      m_dv = (m_run >= S) && (dec(m_last) >= 0);
    end
  endtask

  task automatic compare();
    chk("digit", int'(digit), m_digit);
    chk("digit_valid", int'(digit_valid), int'(m_dv));
    chk("new_digit", int'(new_digit), int'(m_nd));
    chk("illegal", int'(illegal), int'(m_ill));
    chk("step_err", int'(step_err), int'(m_se));
    chk("err_cnt", int'(err_cnt), m_err);
    chk("dig_cnt", int'(dig_cnt), m_dig);
  endtask

  task automatic tally_clear();
    nd_cnt = 0; se_cnt = 0; ill_cnt = 0; saw8 = 0;
  endtask

  task automatic cyc(input logic [7:0] p, input logic c);
    seg_in = p;
    clr    = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    nd_cnt  += int'(new_digit);
    se_cnt  += int'(step_err);
    ill_cnt += int'(illegal);
    if (new_digit && digit == 4'd8) saw8++;
    clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digit"}, int'(digit), 0);
    chk({tag, "_dv"}, int'(digit_valid), 0);
    chk({tag, "_nd"}, int'(new_digit), 0);
    chk({tag, "_ill"}, int'(illegal), 0);
    chk({tag, "_se"}, int'(step_err), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
    chk({tag, "_dig"}, int'(dig_cnt), 0);
  endtask

  logic [7:0] seq_b [6] = '{8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h3F};
  logic [7:0] seq_c [3] = '{8'h6D, 8'h7D, 8'h6F};

  initial begin
    rst_syn = 1'b0; clr = 1'b0; seg_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst_syn = 1'b1;

    // single digit held 3 cycles
    tally_clear();
    repeat (3) cyc(8'h6D, 1'b0);
    chk("A_pulses", nd_cnt, 1);
    chk("A_digit", int'(digit), 5);
    chk("A_dv", int'(digit_valid), 1);
    chk("A_dig_cnt", int'(dig_cnt), 1);
    chk("A_err_cnt", int'(err_cnt), 0);
    cyc(8'h6D, 1'b1);
    chk("clr_dig_cnt", int'(dig_cnt), 0);
    chk("clr_dv", int'(digit_valid), 0);
    chk("clr_digit_held", int'(digit), 5);

    // in-order sequence with 9->0 wrap
    tally_clear();
    foreach (seq_b[i]) repeat (2) cyc(seq_b[i], 1'b0);
    chk("B_pulses", nd_cnt, 6);
    chk("B_step_err", se_cnt, 0);
    chk("B_dig_cnt", int'(dig_cnt), 6);
    chk("B_digit", int'(digit), 0);
    cyc(8'h3F, 1'b1);

    // 5, 6, then jump to 9
    tally_clear();
    foreach (seq_c[i]) repeat (2) cyc(seq_c[i], 1'b0);
    chk("C_step_err", se_cnt, 1);
    chk("C_err_cnt", int'(err_cnt), 1);
    chk("C_digit", int'(digit), 9);
    cyc(8'h6F, 1'b1);

    // one-cycle glitch to 8 inside a held 5
    tally_clear();
    repeat (3) cyc(8'h6D, 1'b0);
    cyc(8'h7F, 1'b0);
    chk("D_dv_glitch", int'(digit_valid), 0);
    repeat (3) cyc(8'h6D, 1'b0);
    chk("D_pulses", nd_cnt, 2);
    chk("D_no_eight", saw8, 0);
    chk("D_step_err", se_cnt, 1);
    chk("D_err_cnt", int'(err_cnt), 1);
    chk("D_digit", int'(digit), 5);
    cyc(8'h6D, 1'b1);

    // illegal pattern then a first digit with cleared history
    tally_clear();
    repeat (2) cyc(8'h00, 1'b0);
    chk("E_illegal", ill_cnt, 1);
    chk("E_dv", int'(digit_valid), 0);
    chk("E_err_cnt", int'(err_cnt), 1);
    chk("E_digit_held", int'(digit), 5);
    repeat (2) cyc(8'h06, 1'b0);
    chk("E_digit", int'(digit), 1);
    chk("E_step_err", se_cnt, 0);
    chk("E_dig_cnt", int'(dig_cnt), 1);

    // async reset mid-settle, then clr coinciding with an acceptance
    cyc(8'h66, 1'b0);
    #2 rst_syn = 1'b0;
    #0.5;
    chk_reset_vals("arst");
    model_reset();
    #0.5 rst_syn = 1'b1;
    tally_clear();
    cyc(8'h6D, 1'b0);
    cyc(8'h6D, 1'b1);
    chk("F_clr_pulse", nd_cnt, 0);
    chk("F_clr_dig_cnt", int'(dig_cnt), 0);
    chk("F_clr_err_cnt", int'(err_cnt), 0);
    repeat (2) cyc(8'h6D, 1'b0);
    chk("F_digit", int'(digit), 5);
    chk("F_dig_cnt", int'(dig_cnt), 1);
    cyc(8'h6D, 1'b1);

    // saturation of both counters
    for (int i = 0; i < 260; i++) begin
      repeat (2) cyc({1'b0, segs[i % 10]}, 1'b0);
    end
    chk("G_dig_sat", int'(dig_cnt), 255);
    chk("G_err_zero", int'(err_cnt), 0);
    for (int i = 0; i < 260; i++) begin
      repeat (2) cyc((i % 2 == 1) ? 8'h01 : 8'h00, 1'b0);
    end
    chk("G_err_sat", int'(err_cnt), 255);
    chk("G_dig_hold", int'(dig_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
